// File: rtl/led_demo_pkg.sv
// Shared types, default timing constants and helpers for the LED demo blocks.
package led_demo_pkg;

    localparam int unsigned DEF_CLK_HZ    = 10_000_000;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_NUM_MODES = 4;

    // Button press classifier states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Step period in cycles for a given rate mode: each mode halves the period.
    function automatic int unsigned period_for(input int unsigned base, input int unsigned mode);
        return base >> mode;
    endfunction

endpackage

// File: rtl/led_counter_multirate_button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// only follows the synchronised input after it has differed for DEBOUNCE_CYC cycles.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 10_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync_0;
    logic          sync_1;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= raw_in;
            sync_1 <= sync_0;
        end
    end

    // Count cycles of disagreement; any agreement restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            level_out  <= 1'b0;
        end else if (sync_1 == level_out) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            stable_cnt <= '0;
            level_out  <= sync_1;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_counter_multirate.sv
// Multi-rate LED counter: a short button press cycles the step rate, a long
// press toggles pause, and a level switch selects the count direction.
//
// state     | meaning
// IDLE      | button released, waiting for a debounced press
// PRESSED   | button held, hold counter running, not yet a long press
// LONG_HELD | long press already acted on, waiting for release
module led_counter_multirate
    import led_demo_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned NUM_MODES       = DEF_NUM_MODES,
    parameter int unsigned BASE_PERIOD_CYC = CLK_HZ,
    parameter int unsigned DEBOUNCE_CYC    = CLK_HZ / 1000,
    parameter int unsigned LONG_CYC        = CLK_HZ / 2,
    localparam int unsigned RW             = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_button,
    input  logic             dir_up,
    output logic [WIDTH-1:0] led_out,
    output logic [RW-1:0]    rate_sel,
    output logic             paused
);

    localparam int unsigned PW     = $clog2(BASE_PERIOD_CYC + 1);
    localparam int unsigned HW     = $clog2(LONG_CYC + 1);
    localparam int unsigned SW     = $clog2(DEBOUNCE_CYC + 3);
    localparam int unsigned SETTLE = DEBOUNCE_CYC + 2;

    press_state_t  state;
    press_state_t  state_nxt;
    logic          btn_level;
    logic          dir_sync_0;
    logic          dir_sync_1;
    logic [HW-1:0] hold_cnt;
    logic          hold_at_long;
    logic          short_press;
    logic          long_press;
    logic [PW-1:0] presc;
    logic [PW-1:0] period_m1;
    logic          tick;
    logic [SW-1:0] settle_cnt;
    logic          armed;

    button_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (push_button),
        .level_out (btn_level)
    );

    // Direction switch only needs metastability protection, not debouncing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_sync_0 <= 1'b0;
            dir_sync_1 <= 1'b0;
        end else begin
            dir_sync_0 <= dir_up;
            dir_sync_1 <= dir_sync_0;
        end
    end

    // A button held through reset must be released before presses count:
    // wait for the sync+debounce pipeline to settle, then arm only on a low level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SW'(SETTLE))
                settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SW'(SETTLE) && !btn_level)
                armed <= 1'b1;
        end
    end

    // Press FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Press FSM next-state logic; a release wins over a coincident long-press threshold.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (armed && btn_level) state_nxt = PRESSED;
            PRESSED:   if (!btn_level)         state_nxt = IDLE;
                       else if (hold_at_long)  state_nxt = LONG_HELD;
            LONG_HELD: if (!btn_level)         state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Press FSM outputs: one-cycle strobes for short and long presses.
    always_comb begin
        short_press = 1'b0;
        long_press  = 1'b0;
        if (state == PRESSED) begin
            short_press = !btn_level;
            long_press  = btn_level && hold_at_long;
        end
    end

    // Hold counter: cleared while idle, advances while the press is undecided.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   hold_cnt <= '0;
        else if (state == IDLE)    hold_cnt <= '0;
        else if (state == PRESSED) hold_cnt <= hold_cnt + 1'b1;
    end

    // The long press fires on the edge where the hold count would reach LONG_CYC.
    assign hold_at_long = (hold_cnt == HW'(LONG_CYC - 1));

    // Rate select and pause flag updated from the press strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_sel <= '0;
            paused   <= 1'b0;
        end else begin
            if (short_press)
                rate_sel <= (rate_sel == RW'(NUM_MODES - 1)) ? '0 : rate_sel + 1'b1;
            if (long_press)
                paused <= ~paused;
        end
    end

    assign period_m1 = PW'(period_for(BASE_PERIOD_CYC, 32'(rate_sel)) - 1);
    assign tick      = !paused && (presc == period_m1);

    // Prescaler: restarts on a rate change, freezes its phase while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              presc <= '0;
        else if (short_press) presc <= '0;
        else if (!paused)     presc <= tick ? '0 : presc + 1'b1;
    end

    // LED counter steps once per tick in the synchronised direction, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       led_out <= '0;
        else if (tick) led_out <= dir_sync_1 ? led_out + 1'b1 : led_out - 1'b1;
    end

endmodule

// File: tb/tb_led_counter_multirate.sv
// Directed bench for led_counter_multirate with shortened timing constants.
module tb_led_counter_multirate;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_button;
    logic       dir_up;
    logic [7:0] led_out;
    logic [1:0] rate_sel;
    logic       paused;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_led_cyc = 0;
    logic [7:0] led_mon = 8'd0;

    led_counter_multirate #(
        .CLK_HZ          (64_000),
        .WIDTH           (8),
        .NUM_MODES       (4),
        .BASE_PERIOD_CYC (64),
        .DEBOUNCE_CYC    (4),
        .LONG_CYC        (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_button (push_button),
        .dir_up      (dir_up),
        .led_out     (led_out),
        .rate_sel    (rate_sel),
        .paused      (paused)
    );

    always #5 clk = ~clk;

    // Edge counter and record of the edge on which led_out last changed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (led_out !== led_mon) begin
            led_mon      = led_out;
            last_led_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_led_step(input int limit, output int n);
        logic [7:0] p;
        p = led_out;
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (led_out !== p) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; push_button = 1'b0; dir_up = 1'b1;
        ticks(3);
        total++; if (led_out !== 8'd0) begin bad++; $display("FAIL reset_led: got %0d want 0", led_out); end
        total++; if (rate_sel !== 2'd0) begin bad++; $display("FAIL reset_rate: got %0d want 0", rate_sel); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused: got %0b want 0", paused); end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int n;
        for (int i = 1; i <= 3; i++) begin
            wait_led_step(100, n);
            total++; if (n != 64) begin bad++; $display("FAIL free_run_period%0d: got %0d want 64", i, n); end
            total++; if (led_out !== 8'(i)) begin bad++; $display("FAIL free_run_value%0d: got %0d want %0d", i, led_out, i); end
        end
        total++; if (rate_sel !== 2'd0) begin bad++; $display("FAIL free_run_rate: got %0d want 0", rate_sel); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL free_run_paused: got %0b want 0", paused); end
    endtask

    task automatic test_short_press();
        int exp_period [4] = '{32, 16, 8, 64};
        logic [1:0] exp_rate [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int n;
        logic [1:0] pr;
        logic [7:0] lp;
        for (int i = 0; i < 4; i++) begin
            pr = rate_sel;
            push_button = 1'b1;
            n = 0;
            while (n < 40) begin
                tick();
                n++;
                if (n == 10) push_button = 1'b0;
                if (rate_sel !== pr) break;
            end
            total++; if (n != 17) begin bad++; $display("FAIL short_latency%0d: got %0d want 17", i, n); end
            total++; if (rate_sel !== exp_rate[i]) begin bad++; $display("FAIL short_rate%0d: got %0d want %0d", i, rate_sel, exp_rate[i]); end
            for (int s = 0; s < 2; s++) begin
                lp = led_out;
                wait_led_step(100, n);
                total++; if (n != exp_period[i]) begin bad++; $display("FAIL short_period%0d_%0d: got %0d want %0d", i, s, n, exp_period[i]); end
                total++; if (led_out !== 8'(lp + 8'd1)) begin bad++; $display("FAIL short_step%0d_%0d: got %0d want %0d", i, s, led_out, 8'(lp + 8'd1)); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] pr;
        logic rose;
        pr = rate_sel;
        rose = 1'b0;
        for (int g = 0; g < 3; g++) begin
            push_button = 1'b1;
            repeat (3) begin tick(); if (dut.btn_level) rose = 1'b1; end
            push_button = 1'b0;
            repeat (8) begin tick(); if (dut.btn_level) rose = 1'b1; end
        end
        ticks(20);
        total++; if (rose !== 1'b0) begin bad++; $display("FAIL glitch_debounce: got rise=%0b want 0", rose); end
        total++; if (rate_sel !== pr) begin bad++; $display("FAIL glitch_rate: got %0d want %0d", rate_sel, pr); end
    endtask

    task automatic test_long_press();
        int n, m, k;
        logic [1:0] pr;
        logic [7:0] frozen;
        pr = rate_sel;
        push_button = 1'b1;
        n = 0;
        while (n < 100) begin tick(); n++; if (paused) break; end
        total++; if (n != 47) begin bad++; $display("FAIL long_pause_latency: got %0d want 47", n); end
        k = cyc - last_led_cyc;
        frozen = led_out;
        while (n < 60) begin tick(); n++; end
        push_button = 1'b0;
        ticks(40);
        total++; if (paused !== 1'b1) begin bad++; $display("FAIL long_paused: got %0b want 1", paused); end
        total++; if (rate_sel !== pr) begin bad++; $display("FAIL long_rate: got %0d want %0d", rate_sel, pr); end
        total++; if (led_out !== frozen) begin bad++; $display("FAIL long_frozen: got %0d want %0d", led_out, frozen); end
        push_button = 1'b1;
        n = 0;
        while (n < 100) begin tick(); n++; if (!paused) break; end
        total++; if (n != 47) begin bad++; $display("FAIL long_resume_latency: got %0d want 47", n); end
        total++; if (led_out !== frozen) begin bad++; $display("FAIL long_still_frozen: got %0d want %0d", led_out, frozen); end
        m = 0;
        while (m < 100) begin
            tick();
            m++;
            if (n + m == 60) push_button = 1'b0;
            if (led_out !== frozen) break;
        end
        total++; if (m != 64 - k) begin bad++; $display("FAIL long_phase: got %0d want %0d", m, 64 - k); end
        total++; if (led_out !== 8'(frozen + 8'd1)) begin bad++; $display("FAIL long_resume_step: got %0d want %0d", led_out, 8'(frozen + 8'd1)); end
        while (n + m < 60) begin tick(); m++; end
        push_button = 1'b0;
        ticks(30);
        total++; if (rate_sel !== pr) begin bad++; $display("FAIL long_rate_after: got %0d want %0d", rate_sel, pr); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL long_unpaused: got %0b want 0", paused); end
    endtask

    task automatic test_direction();
        int n;
        logic [7:0] exp_val [4] = '{8'd255, 8'd254, 8'd255, 8'd0};
        rst = 1'b1; dir_up = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) dir_up = 1'b1;
            wait_led_step(100, n);
            total++; if (n != 64) begin bad++; $display("FAIL dir_period%0d: got %0d want 64", i, n); end
            total++; if (led_out !== exp_val[i]) begin bad++; $display("FAIL dir_value%0d: got %0d want %0d", i, led_out, exp_val[i]); end
        end
    endtask

    task automatic test_reset_mid_press();
        int n;
        rst = 1'b1; dir_up = 1'b1;
        tick();
        rst = 1'b0;
        ticks(10);
        repeat (2) begin
            push_button = 1'b1; ticks(10);
            push_button = 1'b0; ticks(10);
        end
        total++; if (rate_sel !== 2'd2) begin bad++; $display("FAIL rmp_setup_rate: got %0d want 2", rate_sel); end
        n = 0;
        while (led_out !== 8'd5 && n < 300) begin tick(); n++; end
        total++; if (led_out !== 8'd5) begin bad++; $display("FAIL rmp_setup_led: got %0d want 5", led_out); end
        push_button = 1'b1;
        ticks(10);
        total++; if (led_out !== 8'd5) begin bad++; $display("FAIL rmp_held_led: got %0d want 5", led_out); end
        #1 rst = 1'b1;
        #1;
        total++; if (led_out !== 8'd0) begin bad++; $display("FAIL rmp_async_led: got %0d want 0", led_out); end
        total++; if (rate_sel !== 2'd0) begin bad++; $display("FAIL rmp_async_rate: got %0d want 0", rate_sel); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL rmp_async_paused: got %0b want 0", paused); end
        tick();
        rst = 1'b0;
        ticks(60);
        push_button = 1'b0;
        ticks(30);
        total++; if (rate_sel !== 2'd0) begin bad++; $display("FAIL rmp_release_rate: got %0d want 0", rate_sel); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL rmp_release_paused: got %0b want 0", paused); end
        push_button = 1'b1; ticks(10);
        push_button = 1'b0; ticks(10);
        total++; if (rate_sel !== 2'd1) begin bad++; $display("FAIL rmp_repress_rate: got %0d want 1", rate_sel); end
    endtask

    initial begin
        rst = 1'b1;
        push_button = 1'b0;
        dir_up = 1'b1;
        test_reset();
        test_free_run();
        test_short_press();
        test_glitch();
        test_long_press();
        test_direction();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_counter_multirate.md
# led_counter_multirate

Parametrised successor to the single-button LED counter: a WIDTH-bit free-running LED counter whose step rate is selected from NUM_MODES binary-divided rates by a debounced push button. A short press advances the rate, a long press toggles pause, and a level input sets count direction. The block sits between the board button/switch pins and the LED bank. The rest of the design uses it as a self-contained demo/diagnostic block.

## Interface
- CLK_HZ, 10_000_000 — clock frequency; informational only, used to derive defaults
- WIDTH, 8 — LED counter width
- NUM_MODES, 4 — number of rates; mode k steps every BASE_PERIOD_CYC >> k cycles
- BASE_PERIOD_CYC, CLK_HZ — mode-0 step period in cycles (1 s); must be ≥ 2^(NUM_MODES-1) × 2
- DEBOUNCE_CYC, CLK_HZ/1000 — required stable cycles before the debounced level changes
- LONG_CYC, CLK_HZ/2 — debounced hold length that counts as a long press
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- push_button  in  1  raw button, active-high, asynchronous to clk
- dir_up  in  1  raw level switch; 1 = count up, 0 = count down
- led_out  out  WIDTH  counter value
- rate_sel  out  $clog2(NUM_MODES) (min 1)  current mode index
- paused  out  1  1 = counter frozen

## Operation
- Reset values: led_out=0, rate_sel=0, paused=0, prescaler=0, FSM=IDLE, debounced level=0. Synchroniser flops also reset to 0.
- push_button and dir_up each pass through a 2-FF synchroniser.
- Debounce: a counter runs while the synchronised button level differs from the debounced level. The debounced level flips when the count reaches DEBOUNCE_CYC. Any return to equality clears the counter.
- Press FSM runs on the debounced level:
  - IDLE: on rise, go to PRESSED and clear the hold counter.
  - PRESSED: the hold counter increments each cycle.
    - On fall before the counter reaches LONG_CYC: short press. rate_sel ← (rate_sel == NUM_MODES-1) ? 0 : rate_sel+1. Go to IDLE.
    - When the counter reaches LONG_CYC: paused ← ~paused. Go to LONG_HELD.
  - LONG_HELD: on fall, go to IDLE with no rate change.
- Prescaler:
  - Counts 0..(BASE_PERIOD_CYC >> rate_sel)-1 and issues a 1-cycle tick at the terminal count, then wraps to 0.
  - Holds its value while paused=1.
  - Clears to 0 in the cycle rate_sel changes.
- On tick: led_out ← led_out ± 1 per synchronised dir_up, modulo 2^WIDTH. Wrap 2^WIDTH-1→0 when counting up and 0→2^WIDTH-1 when counting down.
- A direction change takes effect on the next tick. It does not reset the prescaler or led_out.
- A rate change in the same cycle as a tick: the tick is applied with the old direction, and the prescaler clears.
- Reset mid-press: the FSM returns to IDLE and the press is discarded. The held button must be released and re-pressed to be seen.

## Timing
- Button edge to debounced change: 2 + DEBOUNCE_CYC cycles when the input is held stable.
- Short press: rate_sel updates 1 cycle after the debounced fall.
- Long press: paused toggles 1 cycle after the hold counter reaches LONG_CYC. This is measured from the debounced rise and happens while the button is still held.
- Step period in mode k: exactly BASE_PERIOD_CYC >> k cycles. led_out updates 1 cycle after the tick.
- The first step after a rate change lands a full new period after the change.
- Pause freezes the prescaler phase. Resume continues from the held count.

## Structure
- Shared package led_demo_pkg holds:
  - press FSM state enum: IDLE, PRESSED, LONG_HELD
  - function `period_for(mode)` returning BASE_PERIOD_CYC >> mode
  - default timing constants
- Sub-module button_debounce: synchroniser plus debounce counter. Parameter DEBOUNCE_CYC. Ports clk, rst, raw_in, level_out. Instantiate once for the button.
- dir_up uses only a plain 2-FF synchroniser.
- Top-level contents: press FSM, hold counter, prescaler, LED counter.

## Test plan
Bench parameters: BASE_PERIOD_CYC=64, NUM_MODES=4, DEBOUNCE_CYC=4, LONG_CYC=40, WIDTH=8.
- Reset then free run with dir_up=1: led_out=0 at reset, then steps 1, 2, 3 every 64 cycles. rate_sel=0, paused=0.
- Four short presses of 10 cycles each: rate_sel goes 1, 2, 3, 0. Step periods are 32, 16, 8, then 64 cycles. Prescaler restarts at each change.
- Button glitches of 3 cycles: no rate change and no debounced transition.
- Hold for 60 cycles: paused=1 exactly 2+4+40(+1) cycles after the press edge. Release leaves rate_sel unchanged and led_out frozen. A second long press resumes counting with the remaining prescaler phase preserved.
- dir_up=0 from led_out=0: the next tick gives 255, then 254. Switch to dir_up=1 at 254: it counts up, and 255→0 wraps.
- Assert rst mid-PRESSED with led_out=5 and rate_sel=2: all outputs go to 0 at once. Releasing the still-held button causes no rate change.
